// File: rtl/ec_point_mul_double_add.sv
`default_nettype none
// ============================================================================
// Module   : ec_point_mul_double_add
// Purpose  : Elliptic-curve scalar multiplier R = k*P on y^2 = x^3 + A*x + B
//            mod PRIME, affine coordinates, left-to-right double-and-add.
//            One multiplication per reset pulse; result held until next reset.
// Ports    : clk    - clock, all state on rising edge
//            Reset  - asynchronous active-low reset, aborts and clears all state
//            P      - base point {x, y}, latched on first edge after reset release
//            k      - scalar, latched together with P
//            R      - result point {x, y}; infinity encoded as {0, 0}
//            Done   - result valid, held high until next reset
// Revision : 1.0 - initial release
// ============================================================================
module ec_point_mul_double_add #(
  parameter int unsigned P_WIDTH = 16,
  parameter int unsigned PRIME   = 907,
  parameter int unsigned A_COEF  = 0
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [2*P_WIDTH-1:0] P,
  input  logic [P_WIDTH-1:0]   k,
  output logic [2*P_WIDTH-1:0] R,
  output logic                 Done
);

  localparam int unsigned        IW          = $clog2(P_WIDTH);
  localparam logic [P_WIDTH-1:0] c_prime     = P_WIDTH'(PRIME);
  localparam logic [P_WIDTH-1:0] c_a         = P_WIDTH'(A_COEF % PRIME);
  localparam logic [IW:0]        c_mul_steps = (IW+1)'(P_WIDTH);

  typedef logic [P_WIDTH-1:0] fe_t;

  typedef enum logic [3:0] {
    ST_LOAD, ST_SCAN, ST_STEP, ST_DBL0, ST_DBL1, ST_ADD0, ST_INV, ST_LAM,
    ST_SQ, ST_X3, ST_Y3, ST_POST, ST_MUL, ST_FIN, ST_DONE
  } state_t;

  // Operands are always < PRIME < 2**(P_WIDTH-1), so sums never overflow P_WIDTH bits.
  function automatic fe_t fadd(input fe_t a, input fe_t b);
    fe_t s;
    s = a + b;
    if (s >= c_prime) s = s - c_prime;
    return s;
  endfunction

  function automatic fe_t fsub(input fe_t a, input fe_t b);
    return (a >= b) ? (a - b) : (a + (c_prime - b));
  endfunction

  // x/2 mod PRIME: odd values become even by adding the (odd) modulus first.
  function automatic fe_t fhalf(input fe_t x);
    return x[0] ? ((x + c_prime) >> 1) : (x >> 1);
  endfunction

  state_t         state_q, state_d, ret_q, ret_d;
  fe_t            px_q, px_d, py_q, py_d, k_q, k_d;
  fe_t            qx_q, qx_d, qy_q, qy_d;
  logic           qinf_q, qinf_d, is_add_q, is_add_d;
  logic [IW-1:0]  rem_q, rem_d;
  fe_t            num_q, num_d, xo_q, xo_d, lam_q, lam_d, x3_q, x3_d;
  fe_t            u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  fe_t            ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [IW:0]    cnt_q, cnt_d;
  logic [2*P_WIDTH-1:0] r_q, r_d;
  logic           done_q, done_d;

  logic [IW-1:0]  w_msb;
  fe_t            w_x3, w_dbl;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < P_WIDTH; i++) begin
      if (k_q[i]) w_msb = IW'(i);
    end
  end

  // Shared slope tail: x3 = lam^2 - Qx - xo, where xo is Qx (double) or Px (add).
  assign w_x3  = fsub(fsub(acc_q, qx_q), xo_q);
  assign w_dbl = fadd(acc_q, acc_q);

  always_comb begin
    state_d = state_q;  ret_d  = ret_q;
    px_d    = px_q;     py_d   = py_q;    k_d    = k_q;
    qx_d    = qx_q;     qy_d   = qy_q;    qinf_d = qinf_q;
    is_add_d = is_add_q; rem_d = rem_q;
    num_d   = num_q;    xo_d   = xo_q;    lam_d  = lam_q;  x3_d = x3_q;
    u_d     = u_q;      v_d    = v_q;     x1_d   = x1_q;   x2_d = x2_q;
    ma_d    = ma_q;     mb_d   = mb_q;    acc_d  = acc_q;  cnt_d = cnt_q;
    r_d     = r_q;      done_d = done_q;

    case (state_q)
      ST_LOAD: begin
        px_d    = P[2*P_WIDTH-1:P_WIDTH];
        py_d    = P[P_WIDTH-1:0];
        k_d     = k;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (k_q == '0) begin
          qinf_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          qx_d    = px_q;
          qy_d    = py_q;
          qinf_d  = 1'b0;
          rem_d   = w_msb;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        is_add_d = 1'b0;
        if (rem_q == '0) begin
          state_d = ST_FIN;
        end else begin
          rem_d   = rem_q - 1'b1;
          state_d = ST_DBL0;
        end
      end
      ST_DBL0: begin
        if (qinf_q || qy_q == '0) begin
          qinf_d  = 1'b1;
          state_d = ST_POST;
        end else begin
          ma_d = qx_q;  mb_d = qx_q;  acc_d = '0;  cnt_d = c_mul_steps;
          ret_d = ST_DBL1;  state_d = ST_MUL;
        end
      end
      ST_DBL1: begin
        num_d = fadd(fadd(fadd(acc_q, acc_q), acc_q), c_a);
        u_d   = fadd(qy_q, qy_q);
        v_d   = c_prime;  x1_d = fe_t'(1);  x2_d = '0;
        xo_d  = qx_q;
        state_d = ST_INV;
      end
      ST_ADD0: begin
        if (qinf_q) begin
          qx_d = px_q;  qy_d = py_q;  qinf_d = 1'b0;
          state_d = ST_POST;
        end else if (qx_q == px_q) begin
          if (qy_q == py_q) state_d = ST_DBL0;
          else begin
            qinf_d  = 1'b1;
            state_d = ST_POST;
          end
        end else begin
          num_d = fsub(py_q, qy_q);
          u_d   = fsub(px_q, qx_q);
          v_d   = c_prime;  x1_d = fe_t'(1);  x2_d = '0;
          xo_d  = px_q;
          state_d = ST_INV;
        end
      end
      // Binary extended Euclid; invariants x1*den == u and x2*den == v (mod PRIME).
      ST_INV: begin
        if (u_q == fe_t'(1)) begin
          state_d = ST_LAM;
        end else if (v_q == fe_t'(1)) begin
          x1_d    = x2_q;
          state_d = ST_LAM;
        end else if (!u_q[0]) begin
          u_d = u_q >> 1;  x1_d = fhalf(x1_q);
        end else if (!v_q[0]) begin
          v_d = v_q >> 1;  x2_d = fhalf(x2_q);
        end else if (u_q >= v_q) begin
          u_d = u_q - v_q;  x1_d = fsub(x1_q, x2_q);
        end else begin
          v_d = v_q - u_q;  x2_d = fsub(x2_q, x1_q);
        end
      end
      ST_LAM: begin
        ma_d = num_q;  mb_d = x1_q;  acc_d = '0;  cnt_d = c_mul_steps;
        ret_d = ST_SQ;  state_d = ST_MUL;
      end
      ST_SQ: begin
        lam_d = acc_q;
        ma_d = acc_q;  mb_d = acc_q;  acc_d = '0;  cnt_d = c_mul_steps;
        ret_d = ST_X3;  state_d = ST_MUL;
      end
      ST_X3: begin
        x3_d = w_x3;
        ma_d = lam_q;  mb_d = fsub(qx_q, w_x3);  acc_d = '0;  cnt_d = c_mul_steps;
        ret_d = ST_Y3;  state_d = ST_MUL;
      end
      ST_Y3: begin
        qx_d    = x3_q;
        qy_d    = fsub(acc_q, qy_q);
        qinf_d  = 1'b0;
        state_d = ST_POST;
      end
      // After a double, follow with an add when the current scalar bit is set.
      ST_POST: begin
        if (!is_add_q && k_q[rem_q]) begin
          is_add_d = 1'b1;
          state_d  = ST_ADD0;
        end else begin
          state_d = ST_STEP;
        end
      end
      // MSB-first shift-add multiply, reduced every step.
      ST_MUL: begin
        acc_d = mb_q[P_WIDTH-1] ? fadd(w_dbl, ma_q) : w_dbl;
        mb_d  = mb_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (IW+1)'(1)) state_d = ret_q;
      end
      ST_FIN: begin
        r_d     = qinf_q ? '0 : {qx_q, qy_q};
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: ;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_LOAD;  ret_q <= ST_LOAD;
      px_q <= '0;  py_q <= '0;  k_q <= '0;
      qx_q <= '0;  qy_q <= '0;  qinf_q <= 1'b0;
      is_add_q <= 1'b0;  rem_q <= '0;
      num_q <= '0;  xo_q <= '0;  lam_q <= '0;  x3_q <= '0;
      u_q <= '0;  v_q <= '0;  x1_q <= '0;  x2_q <= '0;
      ma_q <= '0;  mb_q <= '0;  acc_q <= '0;  cnt_q <= '0;
      r_q <= '0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  ret_q <= ret_d;
      px_q <= px_d;  py_q <= py_d;  k_q <= k_d;
      qx_q <= qx_d;  qy_q <= qy_d;  qinf_q <= qinf_d;
      is_add_q <= is_add_d;  rem_q <= rem_d;
      num_q <= num_d;  xo_q <= xo_d;  lam_q <= lam_d;  x3_q <= x3_d;
      u_q <= u_d;  v_q <= v_d;  x1_q <= x1_d;  x2_q <= x2_d;
      ma_q <= ma_d;  mb_q <= mb_d;  acc_q <= acc_d;  cnt_q <= cnt_d;
      r_q <= r_d;  done_q <= done_d;
    end
  end

  assign R    = r_q;
  assign Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ec_point_mul_double_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_ec_point_mul_double_add
// Purpose  : Self-checking bench for ec_point_mul_double_add against a
//            behavioural group-law model (right-to-left scalar multiply).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ec_point_mul_double_add;

  localparam int W     = 16;
  localparam int PR    = 907;
  localparam int AC    = 0;
  localparam int BC    = 173;
  localparam int BOUND = 4 * W * W * W;

  typedef struct packed {
    logic inf;
    int   x;
    int   y;
  } pt_t;

  logic           clk;
  logic           Reset;
  logic [2*W-1:0] P;
  logic [W-1:0]   k;
  logic [2*W-1:0] R;
  logic           Done;

  int n_checks;
  int n_errors;

  ec_point_mul_double_add #(.P_WIDTH(W), .PRIME(PR), .A_COEF(AC)) dut (
    .clk   (clk),
    .Reset (Reset),
    .P     (P),
    .k     (k),
    .R     (R),
    .Done  (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int md(input int v);
    int r;
    r = v % PR;
    if (r < 0) r += PR;
    return r;
  endfunction

  function automatic int minv(input int a);
    int r, b, e;
    r = 1;  b = md(a);  e = PR - 2;
    while (e > 0) begin
      if (e % 2 == 1) r = md(r * b);
      b = md(b * b);
      e = e / 2;
    end
    return r;
  endfunction

  function automatic pt_t mk_pt(input int x, input int y);
    pt_t p;
    p.inf = 1'b0;  p.x = x;  p.y = y;
    return p;
  endfunction

  function automatic pt_t pt_add(input pt_t a, input pt_t b);
    pt_t r;
    int  lam;
    r = '0;
    r.inf = 1'b1;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x) begin
      if (md(a.y + b.y) == 0) return r;
      lam = md(md(3 * a.x * a.x + AC) * minv(2 * a.y));
    end else begin
      lam = md(md(b.y - a.y) * minv(b.x - a.x));
    end
    r.inf = 1'b0;
    r.x   = md(lam * lam - a.x - b.x);
    r.y   = md(lam * (a.x - r.x) - a.y);
    return r;
  endfunction

  function automatic pt_t smul(input pt_t p, input int kk);
    pt_t acc, base;
    int  e;
    acc = '0;  acc.inf = 1'b1;
    base = p;  e = kk;
    while (e > 0) begin
      if (e % 2 == 1) acc = pt_add(acc, base);
      base = pt_add(base, base);
      e = e / 2;
    end
    return acc;
  endfunction

  function automatic int pt_order(input pt_t p);
    pt_t q;
    int  n;
    q = p;  n = 1;
    while (!q.inf && n < 4 * PR) begin
      q = pt_add(q, p);
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] enc(input pt_t p);
    return p.inf ? 32'h0 : {p.x[15:0], p.y[15:0]};
  endfunction

  function automatic pt_t rand_pt();
    int x;
    for (int tries = 0; tries < 1000; tries++) begin
      x = int'($urandom_range(0, PR - 1));
      for (int y = 1; y < PR; y++) begin
        if (md(y * y) == md(md(x * x) * x + BC)) return mk_pt(x, y);
      end
    end
    return mk_pt(6, 36);
  endfunction

  // ---------------- one multiplication ----------------
  task automatic run_vec(input string tag, input int x, input int y, input int kk, output int lat);
    logic [31:0] exp_r;
    int          cyc;
    bit          early, unstable;
    exp_r = enc(smul(mk_pt(x, y), kk));
    Reset = 1'b0;
    P = {x[15:0], y[15:0]};
    k = kk[15:0];
    repeat (2) @(negedge clk);
    chk($sformatf("%s_rst_done", tag), {31'b0, Done}, 32'h0);
    chk($sformatf("%s_rst_r", tag), R, 32'h0);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    // Inputs after the load edge must be ignored.
    P = $urandom;
    k = W'($urandom);
    cyc = 0;  early = 1'b0;
    while (!Done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (!Done && R !== 32'h0) early = 1'b1;
    end
    chk($sformatf("%s_done_in_bound", tag), {31'b0, Done}, 32'h1);
    chk($sformatf("%s_r_zero_before_done", tag), {31'b0, early}, 32'h0);
    chk($sformatf("%s_r", tag), R, exp_r);
    unstable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (R !== exp_r || Done !== 1'b1) unstable = 1'b1;
    end
    chk($sformatf("%s_stable", tag), {31'b0, unstable}, 32'h0);
    lat = cyc;
  endtask

  initial begin
    int  lat0, lat1, ord;
    pt_t rp;
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b0;
    P = '0;
    k = '0;

    run_vec("k1", 6, 36, 1, lat0);
    chk("k1_const", R, {16'd6, 16'd36});

    run_vec("k2", 6, 36, 2, lat0);
    chk("k2_const", R, {16'd217, 16'd101});

    run_vec("k0", 6, 36, 0, lat0);
    chk("k0_done", {31'b0, Done}, 32'h1);

    run_vec("k38a", 6, 36, 38, lat0);
    run_vec("k38b", 6, 36, 38, lat1);
    chk("latency_deterministic", lat1, lat0);

    // Asynchronous reset after completion: outputs clear without a clock edge.
    @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_done", {31'b0, Done}, 32'h0);
    chk("async_rst_r", R, 32'h0);

    run_vec("p2_k58", 32, 17, 58, lat0);

    ord = pt_order(mk_pt(6, 36));
    run_vec("k_order", 6, 36, ord, lat0);
    chk("k_order_inf", R, 32'h0);
    run_vec("k_order_p1", 6, 36, ord + 1, lat0);
    chk("k_order_p1_const", R, {16'd6, 16'd36});

    // Abort a long computation partway through.
    Reset = 1'b0;
    P = {16'd6, 16'd36};
    k = 16'hFFFF;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    repeat (700) @(negedge clk);
    chk("mid_busy_done", {31'b0, Done}, 32'h0);
    #3 Reset = 1'b0;
    #1;
    chk("mid_abort_done", {31'b0, Done}, 32'h0);
    chk("mid_abort_r", R, 32'h0);
    run_vec("after_abort", 32, 17, 1234, lat0);

    for (int i = 0; i < 10; i++) begin
      rp = rand_pt();
      run_vec($sformatf("rnd%0d", i), rp.x, rp.y, int'($urandom_range(0, 4095)), lat0);
    end
    rp = rand_pt();
    run_vec("rnd_full", rp.x, rp.y, 65535, lat0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
